dual_stack_arbiter: RTL and testbench

- Shared hardware stack for two recursive-function controllers, e.g. a Fibonacci engine and a factorial engine, each using push/pop/top frames.
- One memory array is split into two equal partitions, one private partition per requester, each with its own stack pointer.
- A round-robin arbiter serialises requester access to the single memory port.
- The block replaces per-engine stacks so two recursive engines can share one storage array.

---
 rtl/dual_stack_arbiter_if.sv | 35 +++
 rtl/dual_stack_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dual_stack_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_stack_arbiter_if.sv
// Command/response bundle between the two recursive engines and the shared stack.
// Handshake: reqN with opN/wdataN is held until the one-cycle gntN pulse; resN is valid with gntN.
interface dual_stack_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              req0;
  logic [1:0]        op0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic [DATA_W-1:0] rdata0;
  logic              err0;
  logic              empty0;
  logic              full0;

  logic              req1;
  logic [1:0]        op1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic [DATA_W-1:0] rdata1;
  logic              err1;
  logic              empty1;
  logic              full1;

  modport master (
    output req0, op0, wdata0, req1, op1, wdata1,
    input  gnt0, rdata0, err0, empty0, full0,
    input  gnt1, rdata1, err1, empty1, full1
  );

  modport slave (
    input  req0, op0, wdata0, req1, op1, wdata1,
    output gnt0, rdata0, err0, empty0, full0,
    output gnt1, rdata1, err1, empty1, full1
  );
endinterface

// File: rtl/dual_stack_arbiter.sv
// Two private stacks in one memory array, each with its own stack pointer,
// served one access at a time by a round-robin IDLE/EXEC/DONE sequencer.
module dual_stack_arbiter #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  dual_stack_arbiter_if.slave   bus,
  output logic [1:0]            o_dbg_state
);
  localparam int            HALF    = DEPTH / 2;
  localparam logic [AW-1:0] HALF_SP = AW'(HALF);
  localparam logic [AW-2:0] ONE_LO  = (AW-1)'(1);

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_TOP   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_sel;
  logic              r_last;
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_wdata;
  logic [AW-1:0]     r_sp0;
  logic [AW-1:0]     r_sp1;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_err0;
  logic              r_err1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_pick;
  logic [AW-1:0]     w_sp_sel;
  logic [AW-2:0]     w_sp_dec_lo;
  logic [AW-1:0]     w_wr_addr;
  logic [AW-1:0]     w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_can_push;
  logic              w_can_pop;
  logic              w_mem_we;
  logic [AW-1:0]     w_sp_next;
  logic              w_res_err;
  logic              w_res_rd_en;
  logic [DATA_W-1:0] w_res_rdata;

  // On a tie the requester that was not served last wins.
  assign w_pick = (bus.req0 && bus.req1) ? ~r_last : bus.req1;

  assign w_sp_sel    = r_sel ? r_sp1 : r_sp0;
  assign w_sp_dec_lo = w_sp_sel[AW-2:0] - ONE_LO;
  assign w_wr_addr   = {r_sel, w_sp_sel[AW-2:0]};
  assign w_rd_addr   = {r_sel, w_sp_dec_lo};
  assign w_rd_data   = r_mem[w_rd_addr];
  assign w_can_push  = (w_sp_sel != HALF_SP);
  assign w_can_pop   = (w_sp_sel != '0);
  assign w_mem_we    = (r_state == S_EXEC) && (r_op == OP_PUSH) && w_can_push;

  always_comb begin
    w_sp_next   = w_sp_sel;
    w_res_err   = 1'b0;
    w_res_rd_en = 1'b0;
    w_res_rdata = '0;
    case (r_op)
      OP_PUSH: begin
        if (w_can_push) w_sp_next = w_sp_sel + AW'(1);
        else            w_res_err = 1'b1;
      end
      OP_POP: begin
        w_res_rd_en = 1'b1;
        if (w_can_pop) begin
          w_res_rdata = w_rd_data;
          w_sp_next   = w_sp_sel - AW'(1);
        end else begin
          w_res_err = 1'b1;
        end
      end
      OP_TOP: begin
        w_res_rd_en = 1'b1;
        if (w_can_pop) w_res_rdata = w_rd_data;
        else           w_res_err   = 1'b1;
      end
      default: w_sp_next = '0;
    endcase
  end

  // Storage is not reset; only the stack pointers define what is live.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_wr_addr] <= r_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sel    <= 1'b0;
      r_last   <= 1'b1;
      r_op     <= OP_PUSH;
      r_wdata  <= '0;
      r_sp0    <= '0;
      r_sp1    <= '0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req0 || bus.req1) begin
            r_sel   <= w_pick;
            r_op    <= w_pick ? bus.op1 : bus.op0;
            r_wdata <= w_pick ? bus.wdata1 : bus.wdata0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_sel) begin
            r_sp1  <= w_sp_next;
            r_gnt1 <= 1'b1;
            r_err1 <= w_res_err;
            if (w_res_rd_en) r_rdata1 <= w_res_rdata;
          end else begin
            r_sp0  <= w_sp_next;
            r_gnt0 <= 1'b1;
            r_err0 <= w_res_err;
            if (w_res_rd_en) r_rdata0 <= w_res_rdata;
          end
          r_last  <= r_sel;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_err0  <= 1'b0;
          r_err1  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_err0  <= 1'b0;
          r_err1  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0   = r_gnt0;
  assign bus.gnt1   = r_gnt1;
  assign bus.err0   = r_err0;
  assign bus.err1   = r_err1;
  assign bus.rdata0 = r_rdata0;
  assign bus.rdata1 = r_rdata1;
  assign bus.empty0 = (r_sp0 == '0);
  assign bus.empty1 = (r_sp1 == '0);
  assign bus.full0  = (r_sp0 == HALF_SP);
  assign bus.full1  = (r_sp1 == HALF_SP);
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_dual_stack_arbiter.sv
// Directed and randomized bench for the shared two-partition stack, checked
// against per-requester queue models of the two stacks.
module tb_dual_stack_arbiter;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int HALF  = DEPTH / 2;

  localparam logic [1:0] PUSH  = 2'b00;
  localparam logic [1:0] POP   = 2'b01;
  localparam logic [1:0] TOP   = 2'b10;
  localparam logic [1:0] CLEAR = 2'b11;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dual_stack_arbiter_if #(.DATA_W(DW)) bus();
  logic [1:0] dbg_state;

  dual_stack_arbiter #(.DATA_W(DW), .DEPTH(DEPTH), .AW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: one LIFO queue per requester plus held read results
  logic [DW-1:0] stk0[$];
  logic [DW-1:0] stk1[$];
  logic [DW-1:0] exp_rd0;
  logic [DW-1:0] exp_rd1;
  int            last_served;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic gnt_of(input int who);
    return (who == 1) ? bus.gnt1 : bus.gnt0;
  endfunction

  function automatic logic err_of(input int who);
    return (who == 1) ? bus.err1 : bus.err0;
  endfunction

  function automatic logic [DW-1:0] rd_of(input int who);
    return (who == 1) ? bus.rdata1 : bus.rdata0;
  endfunction

  task automatic model(input int who, input logic [1:0] op, input logic [DW-1:0] wd,
                       output logic e_err, output logic rd_chk, output logic [DW-1:0] e_rd);
    logic [DW-1:0] s[$];
    if (who == 0) s = stk0; else s = stk1;
    e_err = 1'b0; rd_chk = 1'b0; e_rd = '0;
    case (op)
      PUSH:  if (s.size() < HALF) s.push_back(wd); else e_err = 1'b1;
      POP:   begin rd_chk = 1'b1; if (s.size() > 0) e_rd = s.pop_back(); else e_err = 1'b1; end
      TOP:   begin rd_chk = 1'b1; if (s.size() > 0) e_rd = s[$];         else e_err = 1'b1; end
      default: s.delete();
    endcase
    if (who == 0) begin
      stk0 = s;
      if (rd_chk) exp_rd0 = e_rd;
    end else begin
      stk1 = s;
      if (rd_chk) exp_rd1 = e_rd;
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_empty0"}, bus.empty0, stk0.size() == 0);
    check({tag, "_full0"},  bus.full0,  stk0.size() == HALF);
    check({tag, "_empty1"}, bus.empty1, stk1.size() == 0);
    check({tag, "_full1"},  bus.full1,  stk1.size() == HALF);
  endtask

  // Called at the sampling point where who's grant is expected.
  task automatic serve(input int who, input logic [1:0] op, input logic [DW-1:0] wd, input string tag);
    logic e_err, rd_chk;
    logic [DW-1:0] e_rd;
    model(who, op, wd, e_err, rd_chk, e_rd);
    check({tag, "_gnt"},       gnt_of(who), 1'b1);
    check({tag, "_gnt_other"}, gnt_of(1 - who), 1'b0);
    check({tag, "_err"},       err_of(who), e_err);
    check({tag, "_err_other"}, err_of(1 - who), 1'b0);
    if (rd_chk) check({tag, "_rdata"}, rd_of(who), e_rd);
    check({tag, "_rdata_other"}, rd_of(1 - who), (who == 1) ? exp_rd0 : exp_rd1);
    check_flags(tag);
    last_served = who;
  endtask

  // driver tasks
  task automatic set_req(input int who, input logic r, input logic [1:0] op, input logic [DW-1:0] wd);
    if (who == 0) begin bus.req0 = r; bus.op0 = op; bus.wdata0 = wd; end
    else          begin bus.req1 = r; bus.op1 = op; bus.wdata1 = wd; end
  endtask

  task automatic do_reset();
    set_req(0, 1'b0, PUSH, '0);
    set_req(1, 1'b0, PUSH, '0);
    rst = 1'b1;
    stk0.delete(); stk1.delete();
    exp_rd0 = '0; exp_rd1 = '0;
    last_served = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic single_op(input int who, input logic [1:0] op, input logic [DW-1:0] wd, input string tag);
    int lat = 0;
    set_req(who, 1'b1, op, wd);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (gnt_of(who) || gnt_of(1 - who)) begin lat = c; break; end
    end
    check({tag, "_latency"}, lat, 2);
    serve(who, op, wd, tag);
    set_req(who, 1'b0, op, wd);
    @(negedge clk);
    check({tag, "_gnt_drop"}, {bus.gnt0, bus.gnt1, bus.err0, bus.err1}, 4'b0);
  endtask

  task automatic dual_op(input logic [1:0] op0, input logic [DW-1:0] wd0,
                         input logic [1:0] op1, input logic [DW-1:0] wd1, input string tag);
    int t0 = 0;
    int t1 = 0;
    int first = 1 - last_served;
    set_req(0, 1'b1, op0, wd0);
    set_req(1, 1'b1, op1, wd1);
    for (int c = 1; c <= 12 && (t0 == 0 || t1 == 0); c++) begin
      @(negedge clk);
      if (bus.gnt0 && t0 == 0) begin
        t0 = c; serve(0, op0, wd0, {tag, "_r0"}); set_req(0, 1'b0, op0, wd0);
      end
      if (bus.gnt1 && t1 == 0) begin
        t1 = c; serve(1, op1, wd1, {tag, "_r1"}); set_req(1, 1'b0, op1, wd1);
      end
    end
    check({tag, "_t_first"},  (first == 0) ? t0 : t1, 2);
    check({tag, "_t_second"}, (first == 0) ? t1 : t0, 5);
    @(negedge clk);
  endtask

  initial begin
    bus.req0 = 1'b0; bus.op0 = PUSH; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.op1 = PUSH; bus.wdata1 = '0;

    // reset state
    do_reset();
    check("rst_gnt",   {bus.gnt0, bus.gnt1}, 2'b00);
    check("rst_err",   {bus.err0, bus.err1}, 2'b00);
    check("rst_rdata", {bus.rdata0, bus.rdata1}, 16'h0);
    check("rst_empty", {bus.empty0, bus.empty1}, 2'b11);
    check("rst_full",  {bus.full0, bus.full1}, 2'b00);
    check("rst_state", dbg_state, 2'd0);

    // single push then pop
    single_op(0, PUSH, 8'h05, "push05");
    single_op(0, POP,  8'h00, "pop05");

    // simultaneous pushes from reset, held to see alternation 0,1,0,1
    do_reset();
    set_req(0, 1'b1, PUSH, 8'h11);
    set_req(1, 1'b1, PUSH, 8'h22);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c % 3 == 2) begin
        if (c == 2 || c == 8) serve(0, PUSH, 8'h11, $sformatf("alt_c%0d", c));
        else                  serve(1, PUSH, 8'h22, $sformatf("alt_c%0d", c));
      end else begin
        check($sformatf("alt_idle_c%0d", c), {bus.gnt0, bus.gnt1}, 2'b00);
      end
    end
    set_req(0, 1'b0, PUSH, 8'h11);
    set_req(1, 1'b0, PUSH, 8'h22);
    @(negedge clk);

    // fill partition 1, overflow, drain
    single_op(1, CLEAR, 8'h00, "clr1");
    for (int i = 1; i <= HALF; i++) single_op(1, PUSH, DW'(i), $sformatf("fill1_%0d", i));
    single_op(1, PUSH, 8'hEE, "ovf1");
    for (int i = 0; i < HALF; i++) single_op(1, POP, 8'h00, $sformatf("drain1_%0d", i));
    single_op(0, POP, 8'h00, "p0_intact_a");
    single_op(0, POP, 8'h00, "p0_intact_b");

    // empty partition 0 underflow, then top
    single_op(0, POP,  8'h00, "pop_empty0");
    single_op(0, TOP,  8'h00, "top_empty0");
    single_op(0, PUSH, 8'h3C, "push3c");
    single_op(0, TOP,  8'h00, "top3c_a");
    single_op(0, TOP,  8'h00, "top3c_b");

    // clear partition 0 without disturbing partition 1
    for (int i = 0; i < 3; i++) single_op(0, PUSH, DW'(8'hA0 + i), $sformatf("pre_clr0_%0d", i));
    single_op(1, PUSH, 8'h5A, "keep1_a");
    single_op(1, PUSH, 8'hA5, "keep1_b");
    single_op(0, CLEAR, 8'h00, "clr0");
    single_op(1, POP, 8'h00, "keep1_pop_a");
    single_op(1, POP, 8'h00, "keep1_pop_b");

    // randomized mix of single and contended commands
    for (int i = 0; i < 60; i++) begin
      logic [1:0] o0, o1;
      o0 = 2'($urandom_range(0, 3));
      o1 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) dual_op(o0, DW'($urandom_range(0, 255)), o1, DW'($urandom_range(0, 255)), $sformatf("rnd%0d_dual", i));
      else single_op(int'($urandom_range(0, 1)), o0, DW'($urandom_range(0, 255)), $sformatf("rnd%0d", i));
    end

    // reset asserted while a push is in EXEC
    set_req(0, 1'b1, PUSH, 8'h77);
    @(posedge clk);
    #2 rst = 1'b1;
    stk0.delete(); stk1.delete();
    exp_rd0 = '0; exp_rd1 = '0;
    last_served = 1;
    #1;
    check("rstx_gnt",   {bus.gnt0, bus.gnt1}, 2'b00);
    check("rstx_state", dbg_state, 2'd0);
    check("rstx_empty", {bus.empty0, bus.empty1}, 2'b11);
    set_req(0, 1'b0, PUSH, 8'h77);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rstx_no_gnt", {bus.gnt0, bus.gnt1}, 2'b00);
    end
    single_op(0, PUSH, 8'h99, "post_rst_push");
    single_op(0, POP,  8'h00, "post_rst_pop");
    check_flags("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
